// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. buffered long-op results.
// Optional WB_BYPASS_EN: idle-cycle long results skip the FIFO.
module reg_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    PIPE_WE,
  input  logic [4:0]              PIPE_ADDR,
  input  logic [XLEN-1:0]         PIPE_DATA,
  input  logic                    LONG_VALID,
  output logic                    LONG_READY,
  input  logic [4:0]              LONG_ADDR,
  input  logic [XLEN-1:0]         LONG_DATA,
  input  logic                    ISSUE_LONG,
  input  logic [4:0]              ISSUE_ADDR,
  input  logic [4:0]              CHK_ADDR1,
  input  logic [4:0]              CHK_ADDR2,
  output logic                    CHK_BUSY1,
  output logic                    CHK_BUSY2,
  output logic                    WRITE_ENABLE,
  output logic [4:0]              WRITE_ADDR,
  output logic [XLEN-1:0]         WRITE_DATA,
  output logic [$clog2(DEPTH):0]  FIFO_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [4:0]      fifo_addr [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [31:0]     pending;
  logic [31:0]     pending_next;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  logic pipe_win;
  logic fifo_empty;
  logic accept;
  logic long_live;
  logic pop;
  logic push;
  logic bypass;

  // Arbitration, handshake and scoreboard next-state
  always_comb begin
    pipe_win   = PIPE_WE && (PIPE_ADDR != 5'd0);
    fifo_empty = (count == '0);
    LONG_READY = !RESET && (count < CW'(DEPTH));
    accept     = LONG_VALID && LONG_READY;
    long_live  = accept && (LONG_ADDR != 5'd0);
    pop        = !pipe_win && !fifo_empty;
`ifdef WB_BYPASS_EN
    bypass     = long_live && fifo_empty && !pipe_win;
`else
    bypass     = 1'b0;
`endif
    push       = long_live && !bypass;
    set_mask   = 32'd0;
    clr_mask   = 32'd0;
    if (ISSUE_LONG)
      set_mask[ISSUE_ADDR] = 1'b1;
    if (pop)
      clr_mask[fifo_addr[head]] = 1'b1;
    if (bypass)
      clr_mask[LONG_ADDR] = 1'b1;
    pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

  // FIFO payload storage, written at the tail on push
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data[tail] <= LONG_DATA;
      fifo_addr[tail] <= LONG_ADDR;
    end
  end

  // FIFO pointers, occupancy and pending bits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= 32'd0;
    end else begin
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      count   <= count + CW'(push) - CW'(pop);
      pending <= pending_next;
    end
  end

  // Registered register-file write port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WRITE_ENABLE <= 1'b0;
      WRITE_ADDR   <= 5'd0;
      WRITE_DATA   <= '0;
    end else if (pipe_win) begin
      WRITE_ENABLE <= 1'b1;
      WRITE_ADDR   <= PIPE_ADDR;
      WRITE_DATA   <= PIPE_DATA;
    end else if (pop) begin
      WRITE_ENABLE <= 1'b1;
      WRITE_ADDR   <= fifo_addr[head];
      WRITE_DATA   <= fifo_data[head];
    end else if (bypass) begin
      WRITE_ENABLE <= 1'b1;
      WRITE_ADDR   <= LONG_ADDR;
      WRITE_DATA   <= LONG_DATA;
    end else begin
      WRITE_ENABLE <= 1'b0;
    end
  end

  // Scoreboard queries and occupancy
  always_comb begin
    CHK_BUSY1  = pending[CHK_ADDR1];
    CHK_BUSY2  = pending[CHK_ADDR2];
    FIFO_COUNT = count;
  end

endmodule
